// File: rtl/batcharger_measavg_if.sv
`default_nettype none
// ============================================================================
// Module      : batcharger_measavg_if
// Description : Bundle between the charger measurement block and its
//               environment (SAR ADC and charge controller).
//               master - environment: drives en, vtok and the raw ADC results.
//               slave  - measurement block: drives requests, filtered results
//                        and status.
// Ports       : en, vtok, vbat/ibat/tbat (raw, 8b),
//               vmeasen/imeasen/tmeasen (requests),
//               vbatf/ibatf/tbatf (filtered, 8b), upd, fvalid, adcerr
// Revision    : 1.0 - initial release
// ============================================================================
interface batcharger_measavg_if;
  logic       en;
  logic       vtok;
  logic [7:0] vbat;
  logic [7:0] ibat;
  logic [7:0] tbat;
  logic       vmeasen;
  logic       imeasen;
  logic       tmeasen;
  logic [7:0] vbatf;
  logic [7:0] ibatf;
  logic [7:0] tbatf;
  logic       upd;
  logic       fvalid;
  logic       adcerr;

  modport master (
    output en, vtok, vbat, ibat, tbat,
    input  vmeasen, imeasen, tmeasen, vbatf, ibatf, tbatf, upd, fvalid, adcerr
  );

  modport slave (
    input  en, vtok, vbat, ibat, tbat,
    output vmeasen, imeasen, tmeasen, vbatf, ibatf, tbatf, upd, fvalid, adcerr
  );
endinterface
`default_nettype wire

// File: rtl/batcharger_measavg.sv
`default_nettype none
// ============================================================================
// Module      : batcharger_measavg
// Description : Round-robin V/I/T measurement sequencer for the battery
//               charger SAR ADC with per-channel result filtering, request
//               timeout detection and an all-channels-valid flag.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               bus  - batcharger_measavg_if.slave (en, vtok, raw results in;
//                      requests, filtered results, upd, fvalid, adcerr out)
// Config      : BATCHARGER_MEASAVG_AVG_EN defined   -> 4-sample averaging
//               BATCHARGER_MEASAVG_AVG_EN undefined -> sample passed through
// Revision    : 1.0 - initial release
// ============================================================================
module batcharger_measavg #(
  parameter int TIMEOUT_CYC = 64,
  parameter int GAP_CYC     = 4
) (
  input wire                  clk,
  input wire                  rst,
  batcharger_measavg_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [1:0] CH_V = 2'd0;
  localparam logic [1:0] CH_I = 2'd1;
  localparam logic [1:0] CH_T = 2'd2;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  state_t          state_q, state_d;
  logic [1:0]      ch_q, ch_d;
  logic [7:0]      tmo_q, tmo_d;
  logic [7:0]      gap_q, gap_d;
  // Capture stage: the sample taken on the vtok edge is applied one edge later.
  logic            cap_vld_q, cap_vld_d;
  logic [1:0]      cap_ch_q, cap_ch_d;
  logic [7:0]      cap_data_q, cap_data_d;
  logic [2:0][7:0] filt_q, filt_d;
  logic            upd_q, upd_d;
  logic [2:0]      seen_q, seen_d;
  logic            fvalid_q, fvalid_d;
  logic            adcerr_q, adcerr_d;
  logic [2:0]      req_q, req_d;
  logic [7:0]      sample;
`ifdef BATCHARGER_MEASAVG_AVG_EN
  logic [2:0][9:0] acc_q, acc_d;
  logic [2:0][1:0] cnt_q, cnt_d;
  logic [9:0]      sum;
`endif

  always_comb begin
    case (ch_q)
      CH_I:    sample = bus.ibat;
      CH_T:    sample = bus.tbat;
      default: sample = bus.vbat;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    cap_vld_d  = 1'b0;
    cap_ch_d   = cap_ch_q;
    cap_data_d = cap_data_q;
    filt_d     = filt_q;
    upd_d      = 1'b0;
    seen_d     = seen_q;
    fvalid_d   = fvalid_q;
    adcerr_d   = adcerr_q;
`ifdef BATCHARGER_MEASAVG_AVG_EN
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sum        = '0;
`endif

    if (!bus.en) begin
      // Disable drops any capture in flight; filtered results are held.
      state_d  = ST_IDLE;
      ch_d     = CH_V;
      tmo_d    = '0;
      gap_d    = '0;
      seen_d   = '0;
      fvalid_d = 1'b0;
      adcerr_d = 1'b0;
`ifdef BATCHARGER_MEASAVG_AVG_EN
      acc_d    = '0;
      cnt_d    = '0;
`endif
    end else begin
      if (cap_vld_q) begin
        for (int i = 0; i < 3; i++) begin
          if (cap_ch_q == 2'(i)) begin
`ifdef BATCHARGER_MEASAVG_AVG_EN
            sum = acc_q[i] + {2'b00, cap_data_q};
            if (cnt_q[i] == 2'd3) begin
              filt_d[i] = sum[9:2];
              acc_d[i]  = '0;
              cnt_d[i]  = '0;
              upd_d     = 1'b1;
              seen_d[i] = 1'b1;
            end else begin
              acc_d[i] = sum;
              cnt_d[i] = cnt_q[i] + 2'd1;
            end
`else
            filt_d[i] = cap_data_q;
            upd_d     = 1'b1;
            seen_d[i] = 1'b1;
`endif
          end
        end
      end
      fvalid_d = fvalid_q | (&seen_d);

      case (state_q)
        ST_IDLE: begin
          state_d = ST_MEAS;
          ch_d    = CH_V;
          tmo_d   = '0;
        end
        ST_MEAS: begin
          // A conversion-complete on the last allowed cycle still counts.
          if (bus.vtok) begin
            cap_vld_d  = 1'b1;
            cap_ch_d   = ch_q;
            cap_data_d = sample;
            state_d    = ST_GAP;
            gap_d      = '0;
          end else if (tmo_q == TMO_LAST) begin
            adcerr_d = 1'b1;
            state_d  = ST_GAP;
            gap_d    = '0;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d = ST_MEAS;
            tmo_d   = '0;
            case (ch_q)
              CH_V:    ch_d = CH_I;
              CH_I:    ch_d = CH_T;
              default: ch_d = CH_V;
            endcase
          end else begin
            gap_d = gap_q + 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Requests are registered from the next state so they are glitch-free.
    req_d = (state_d == ST_MEAS) ? (3'b001 << ch_d) : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ch_q       <= CH_V;
      tmo_q      <= '0;
      gap_q      <= '0;
      cap_vld_q  <= 1'b0;
      cap_ch_q   <= CH_V;
      cap_data_q <= '0;
      filt_q     <= '0;
      upd_q      <= 1'b0;
      seen_q     <= '0;
      fvalid_q   <= 1'b0;
      adcerr_q   <= 1'b0;
      req_q      <= '0;
`ifdef BATCHARGER_MEASAVG_AVG_EN
      acc_q      <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      cap_vld_q  <= cap_vld_d;
      cap_ch_q   <= cap_ch_d;
      cap_data_q <= cap_data_d;
      filt_q     <= filt_d;
      upd_q      <= upd_d;
      seen_q     <= seen_d;
      fvalid_q   <= fvalid_d;
      adcerr_q   <= adcerr_d;
      req_q      <= req_d;
`ifdef BATCHARGER_MEASAVG_AVG_EN
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.vmeasen = req_q[0];
  assign bus.imeasen = req_q[1];
  assign bus.tmeasen = req_q[2];
  assign bus.vbatf   = filt_q[0];
  assign bus.ibatf   = filt_q[1];
  assign bus.tbatf   = filt_q[2];
  assign bus.upd     = upd_q;
  assign bus.fvalid  = fvalid_q;
  assign bus.adcerr  = adcerr_q;

endmodule
`default_nettype wire

// File: tb/tb_batcharger_measavg.sv
`default_nettype none
// ============================================================================
// Module      : tb_batcharger_measavg
// Description : Self-checking bench for batcharger_measavg. A reference model
//               pushes expected filtered updates to a queue when a conversion
//               is answered; they are popped when the DUT pulses upd.
//               Honours BATCHARGER_MEASAVG_AVG_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_batcharger_measavg;

  localparam int TIMEOUT_CYC = 64;
  localparam int GAP_CYC     = 4;

  logic clk;
  logic rst;

  batcharger_measavg_if bus ();

  batcharger_measavg #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .GAP_CYC    (GAP_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp;
  int         n_bad;
  logic [7:0] filt_m [3];
  logic [9:0] acc_m  [3];
  int         cnt_m  [3];
  logic [2:0] seen_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic req_of(input int ch);
    case (ch)
      0:       return bus.vmeasen;
      1:       return bus.imeasen;
      default: return bus.tmeasen;
    endcase
  endfunction

  function automatic logic [7:0] filt_of(input int ch);
    case (ch)
      0:       return bus.vbatf;
      1:       return bus.ibatf;
      default: return bus.tbatf;
    endcase
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      acc_m[c] = '0;
      cnt_m[c] = 0;
    end
    seen_m = '0;
    sb.delete();
  endtask

  task automatic model_reset();
    model_clear();
    for (int c = 0; c < 3; c++) filt_m[c] = '0;
  endtask

  task automatic model_sample(input int ch, input logic [7:0] d);
    exp_t       e;
    logic [9:0] s;
`ifdef BATCHARGER_MEASAVG_AVG_EN
    s = acc_m[ch] + {2'b00, d};
    if (cnt_m[ch] == 3) begin
      filt_m[ch] = s[9:2];
      acc_m[ch]  = '0;
      cnt_m[ch]  = 0;
      seen_m[ch] = 1'b1;
      e.ch = ch; e.val = s[9:2];
      sb.push_back(e);
    end else begin
      acc_m[ch] = s;
      cnt_m[ch]++;
    end
`else
    s = {2'b00, d};
    filt_m[ch] = s[7:0];
    seen_m[ch] = 1'b1;
    e.ch = ch; e.val = d;
    sb.push_back(e);
`endif
  endtask

  task automatic restart();
    bus.en = 1'b0;
    tick();
    model_clear();
    bus.en = 1'b1;
    tick();
  endtask

  // Wait for the request of ch, answer after `delay` cycles, then check the
  // filtered update one edge after the capture edge.
  task automatic service(input int ch, input logic [7:0] d, input int delay);
    bit   found;
    bit   exp_upd;
    exp_t e;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (req_of(ch) === 1'b1) found = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL req_wait_ch%0d: request stayed low, required high within 40 cycles", ch);
    end else begin
      n_cmp++;
      if ({bus.tmeasen, bus.imeasen, bus.vmeasen} !== (3'b001 << ch)) begin
        n_bad++;
        $display("FAIL req_onehot_ch%0d: got %b required %b", ch,
                 {bus.tmeasen, bus.imeasen, bus.vmeasen}, 3'b001 << ch);
      end
      repeat (delay) tick();
      bus.vbat = (ch == 0) ? d : ~d;
      bus.ibat = (ch == 1) ? d : ~d;
      bus.tbat = (ch == 2) ? d : ~d;
      bus.vtok = 1'b1;
      model_sample(ch, d);
      tick();
      bus.vtok = 1'b0;
      n_cmp++;
      if (bus.upd !== 1'b0) begin
        n_bad++;
        $display("FAIL upd_early_ch%0d: got %b required 0", ch, bus.upd);
      end
      tick();
      exp_upd = (sb.size() > 0);
      n_cmp++;
      if (bus.upd !== exp_upd) begin
        n_bad++;
        $display("FAIL upd_ch%0d: got %b required %b", ch, bus.upd, exp_upd);
      end
      if (exp_upd) begin
        e = sb.pop_front();
        n_cmp++;
        if (filt_of(e.ch) !== e.val) begin
          n_bad++;
          $display("FAIL filt_ch%0d: got %h required %h", e.ch, filt_of(e.ch), e.val);
        end
      end
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if (filt_of(c) !== filt_m[c]) begin
          n_bad++;
          $display("FAIL hold_ch%0d: got %h required %h", c, filt_of(c), filt_m[c]);
        end
      end
      n_cmp++;
      if (bus.fvalid !== (&seen_m)) begin
        n_bad++;
        $display("FAIL fvalid_after_ch%0d: got %b required %b", ch, bus.fvalid, &seen_m);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b1; bus.vtok = 1'b0;
    bus.vbat = '0; bus.ibat = '0; bus.tbat = '0;
    model_reset();
    tick(); tick();
    n_cmp++;
    if ({bus.vmeasen, bus.imeasen, bus.tmeasen, bus.vbatf, bus.ibatf, bus.tbatf,
         bus.upd, bus.fvalid, bus.adcerr} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got req=%b%b%b f=%h/%h/%h upd=%b fv=%b err=%b required all 0",
               bus.vmeasen, bus.imeasen, bus.tmeasen, bus.vbatf, bus.ibatf, bus.tbatf,
               bus.upd, bus.fvalid, bus.adcerr);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({bus.vmeasen, bus.imeasen, bus.tmeasen} !== 3'b100) begin
      n_bad++;
      $display("FAIL first_request: got v/i/t=%b%b%b required 100",
               bus.vmeasen, bus.imeasen, bus.tmeasen);
    end
    n_cmp++;
    if ({bus.vbatf, bus.ibatf, bus.tbatf, bus.upd, bus.fvalid, bus.adcerr} !== '0) begin
      n_bad++;
      $display("FAIL first_request_others: got f=%h/%h/%h upd=%b fv=%b err=%b required 0",
               bus.vbatf, bus.ibatf, bus.tbatf, bus.upd, bus.fvalid, bus.adcerr);
    end
  endtask

  task automatic test_filter();
`ifdef BATCHARGER_MEASAVG_AVG_EN
    for (int r = 0; r < 4; r++) begin
      service(0, 8'h99 + 8'(r), 2);
      service(1, 8'h10, 1);
      service(2, 8'h10, 3);
    end
    n_cmp++;
    if (bus.vbatf !== 8'h9A) begin
      n_bad++;
      $display("FAIL avg_vbatf: got %h required 9a", bus.vbatf);
    end
`else
    service(0, 8'hC1, 2);
    n_cmp++;
    if (bus.vbatf !== 8'hC1) begin
      n_bad++;
      $display("FAIL direct_vbatf: got %h required c1", bus.vbatf);
    end
    service(1, 8'h3C, 0);
    service(2, 8'h7F, 5);
`endif
  endtask

  task automatic test_timeout();
    int hi;
    int lo;
    restart();
    hi = 0;
    while (bus.vmeasen === 1'b1 && hi < 200) begin
      hi++;
      tick();
    end
    n_cmp++;
    if (hi != TIMEOUT_CYC) begin
      n_bad++;
      $display("FAIL timeout_len: got %0d cycles required %0d", hi, TIMEOUT_CYC);
    end
    n_cmp++;
    if (bus.adcerr !== 1'b1) begin
      n_bad++;
      $display("FAIL adcerr_set: got %b required 1", bus.adcerr);
    end
    lo = 0;
    while ({bus.vmeasen, bus.imeasen, bus.tmeasen} === 3'b000 && lo < 20) begin
      lo++;
      tick();
    end
    n_cmp++;
    if (lo != GAP_CYC || bus.imeasen !== 1'b1) begin
      n_bad++;
      $display("FAIL gap_then_i: got %0d idle, imeasen=%b required %0d idle, imeasen=1",
               lo, bus.imeasen, GAP_CYC);
    end
    service(1, 8'h21, 0);
    service(2, 8'h22, 1);
    service(0, 8'h23, 2);
    n_cmp++;
    if (bus.adcerr !== 1'b1) begin
      n_bad++;
      $display("FAIL adcerr_sticky: got %b required 1", bus.adcerr);
    end
    bus.en = 1'b0;
    tick();
    model_clear();
    n_cmp++;
    if (bus.adcerr !== 1'b0 || bus.fvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL adcerr_clear: got err=%b fv=%b required 0 0", bus.adcerr, bus.fvalid);
    end
  endtask

  task automatic test_timeout_edge();
    restart();
    service(0, 8'h5A, TIMEOUT_CYC - 1);
    n_cmp++;
    if (bus.adcerr !== 1'b0) begin
      n_bad++;
      $display("FAIL late_vtok_adcerr: got %b required 0", bus.adcerr);
    end
  endtask

  task automatic test_back_to_back();
    // vtok during GAP must be ignored.
    service(1, 8'h44, 0);
    bus.vtok = 1'b1;
    bus.vbat = 8'hFF; bus.ibat = 8'hFF; bus.tbat = 8'hFF;
    tick(); tick();
    bus.vtok = 1'b0;
    tick();
    n_cmp++;
    if (bus.upd !== 1'b0 || filt_of(1) !== filt_m[1] || filt_of(2) !== filt_m[2]) begin
      n_bad++;
      $display("FAIL gap_vtok_ignored: got upd=%b i=%h t=%h required 0 %h %h",
               bus.upd, filt_of(1), filt_of(2), filt_m[1], filt_m[2]);
    end
    service(2, 8'h45, 0);
  endtask

  task automatic test_en_drop();
    bit found;
    restart();
    for (int r = 0; r < 3; r++) begin
      service(0, 8'h80 + 8'(4 * r), 1);
      service(1, 8'h20 + 8'(r), 0);
      service(2, 8'h60 - 8'(r), 2);
    end
    service(0, 8'h8C, 0);
    service(1, 8'h23, 0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (bus.tmeasen === 1'b1) found = 1'b1;
      else tick();
    end
    tick(); tick();
    bus.en = 1'b0;
    tick();
    model_clear();
    n_cmp++;
    if (!found || bus.tmeasen !== 1'b0 || bus.fvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL en_drop: got seen=%b tmeasen=%b fvalid=%b required 1 0 0",
               found, bus.tmeasen, bus.fvalid);
    end
    n_cmp++;
    if (bus.vbatf !== filt_m[0] || bus.ibatf !== filt_m[1]) begin
      n_bad++;
      $display("FAIL en_drop_hold: got v=%h i=%h required %h %h",
               bus.vbatf, bus.ibatf, filt_m[0], filt_m[1]);
    end
    bus.en = 1'b1;
    tick();
    n_cmp++;
    if ({bus.vmeasen, bus.imeasen, bus.tmeasen} !== 3'b100) begin
      n_bad++;
      $display("FAIL restart_v: got v/i/t=%b%b%b required 100",
               bus.vmeasen, bus.imeasen, bus.tmeasen);
    end
`ifdef BATCHARGER_MEASAVG_AVG_EN
    for (int r = 0; r < 4; r++) begin
      service(0, 8'h40, 0);
      service(1, 8'h08, 0);
      service(2, 8'h30, 0);
    end
`else
    service(0, 8'h40, 0);
    service(1, 8'h08, 0);
    service(2, 8'h30, 0);
`endif
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (bus.vmeasen === 1'b1) found = 1'b1;
      else tick();
    end
    rst = 1'b1;
    tick();
    model_reset();
    n_cmp++;
    if (!found || {bus.vmeasen, bus.imeasen, bus.tmeasen, bus.vbatf, bus.ibatf,
                   bus.tbatf, bus.fvalid, bus.adcerr} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_meas: got seen=%b req=%b%b%b f=%h/%h/%h required 1, all 0",
               found, bus.vmeasen, bus.imeasen, bus.tmeasen, bus.vbatf, bus.ibatf, bus.tbatf);
    end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_filter();
    test_timeout();
    test_timeout_edge();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/batcharger_measavg.md
BATCHARGER_MEASAVG -- requirements
Module: batcharger_measavg

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64: maximum cycles a channel request waits for vtok (range 2..255).
REQ-002 SHALL have parameter GAP_CYC, default 4: idle cycles between consecutive channel requests (range 1..255).
REQ-003 SHALL have port clk  in  1  digital state machine clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  in  1  block enable (dvdd domain).
REQ-006 SHALL have port vtok  in  1  SAR ADC conversion-complete pulse, one cycle.
REQ-007 SHALL have ports vbat, ibat, tbat  in  8 each  raw SAR ADC results for voltage, current and temperature.
REQ-008 SHALL have ports vmeasen, imeasen, tmeasen  out  1 each  per-channel conversion requests to the SAR ADC.
REQ-009 SHALL have ports vbatf, ibatf, tbatf  out  8 each  filtered results consumed by the charge controller.
REQ-010 SHALL have port upd  out  1  one-cycle pulse, a filtered output changed this cycle.
REQ-011 SHALL have port fvalid  out  1  all three filtered outputs updated since en last rose.
REQ-012 SHALL have port adcerr  out  1  sticky flag, a request timed out.

Function
REQ-013 SHALL implement FSM states IDLE, MEAS, GAP, with a channel register ch in {V, I, T}.
REQ-014 IDLE: all requests low; when en=1 is sampled, the FSM SHALL go to MEAS with ch=V and the timeout counter at 0.
REQ-015 MEAS: only the request for ch SHALL be high (one-hot); the timeout counter SHALL increment every cycle.
REQ-016 MEAS with vtok=1: the ch input SHALL be sampled on that edge, processed per REQ-019/020, and the FSM SHALL go to GAP.
REQ-017 MEAS at count TIMEOUT_CYC-1 with vtok=0: adcerr SHALL be set, the sample discarded, and the FSM SHALL go to GAP; if vtok=1 on the same cycle, vtok wins and adcerr is not set.
REQ-018 GAP: all requests SHALL be low for GAP_CYC cycles, then ch SHALL advance V->I->T->V and the FSM SHALL return to MEAS; vtok SHALL be ignored in IDLE and GAP.
REQ-019 Averaging: each channel SHALL have a 10-bit accumulator and a 2-bit sample count; on the 4th sample the filtered output SHALL become (acc+sample)>>2 (truncated), and the accumulator and count SHALL clear.
REQ-020 A filtered register update SHALL be visible on the edge following the capture edge, with upd=1 in that same cycle; other channels hold their values.
REQ-021 fvalid SHALL set in the cycle the last of the three channels first updates after en rises.
REQ-022 When en=0 is sampled in any state, the block SHALL enter IDLE next cycle: requests low; accumulators, counts, fvalid and adcerr cleared; filtered outputs held.
REQ-023 Accumulator arithmetic SHALL NOT overflow (4 x 255 = 1020 < 1024).

Reset
REQ-024 When rst=1, the next edge SHALL set state IDLE, ch=V, and all counters, accumulators and outputs to 0; rst SHALL override en.
REQ-025 Reset asserted mid-MEAS SHALL drop the active request on the next edge and discard the partial average.

Configuration
REQ-026 Macro BATCHARGER_MEASAVG_AVG_EN defined: 4-sample averaging per REQ-019.
REQ-027 Macro BATCHARGER_MEASAVG_AVG_EN undefined: no accumulators; each captured sample SHALL load the filtered output directly, with the same latency and upd timing as REQ-020.

Verification
REQ-028 rst 1 then 0, en=1 -> vmeasen=1 on the edge after en is sampled; imeasen=tmeasen=0; all other outputs 0.
REQ-029 AVG_EN defined, V conversions 0x99, 0x9A, 0x9B, 0x9C (I and T answered 0x10) -> vbatf=0x9A on the 4th V capture with a one-cycle upd; vbatf unchanged after the first three.
REQ-030 No vtok while vmeasen=1 -> vmeasen high exactly 64 cycles, adcerr=1, 4 idle cycles, then imeasen=1; adcerr stays 1 until en=0.
REQ-031 vtok arriving on timeout cycle 63 -> sample accepted, adcerr=0.
REQ-032 en dropped mid-T request after 3 full rounds -> tmeasen low next cycle, fvalid=0, vbatf/ibatf hold; en re-raised -> sequence restarts at V with empty accumulators.
REQ-033 AVG_EN undefined, one V conversion of 0xC1 -> vbatf=0xC1 with upd pulse one cycle after the vtok edge.
